// File: rtl/vga_wr_arbiter.sv
// rtl/vga_wr_arbiter.sv - round-robin two-requester framebuffer write arbiter with bounded bursts
// Optional per-requester beat counters are built when VGA_ARB_STATS_EN is defined.
module vga_wr_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 64,
  parameter int BURST_W   = 7
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dwrite,
  output logic              wr,
  output logic [1:0]        owner
`ifdef VGA_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       a_cnt,
  output logic [15:0]       b_cnt
`endif
);

  // Encoding doubles as the owner code, so owner is a straight flop output.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } state_t;

  state_t             state;
  logic               last_b;
  logic [BURST_W-1:0] beat_cnt;
  logic               acc_a;
  logic               acc_b;
  logic [BURST_W-1:0] cnt_inc;
  logic               at_limit;

  assign a_ready  = wr_en & (state == GNT_A);
  assign b_ready  = wr_en & (state == GNT_B);
  assign acc_a    = a_valid & a_ready;
  assign acc_b    = b_valid & b_ready;
  assign cnt_inc  = beat_cnt + BURST_W'(1);
  assign at_limit = (cnt_inc == BURST_W'(MAX_BURST));
  assign owner    = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      beat_cnt <= '0;
      addr     <= '0;
      dwrite   <= '0;
      wr       <= 1'b0;
    end else begin
      wr <= acc_a | acc_b;
      if (acc_a) begin
        addr   <= a_addr;
        dwrite <= a_data;
      end else if (acc_b) begin
        addr   <= b_addr;
        dwrite <= b_data;
      end

      if (wr_en) begin
        case (state)
          IDLE: begin
            if (a_valid && (!b_valid || last_b)) state <= GNT_A;
            else if (b_valid)                    state <= GNT_B;
          end
          GNT_A: begin
            if (!a_valid) begin
              beat_cnt <= '0;
              last_b   <= 1'b0;
              state    <= b_valid ? GNT_B : IDLE;
            end else if (at_limit) begin
              // Limit reached with no contender: keep the grant, restart the count.
              beat_cnt <= '0;
              if (b_valid) begin
                last_b <= 1'b0;
                state  <= GNT_B;
              end
            end else begin
              beat_cnt <= cnt_inc;
            end
          end
          GNT_B: begin
            if (!b_valid) begin
              beat_cnt <= '0;
              last_b   <= 1'b1;
              state    <= a_valid ? GNT_A : IDLE;
            end else if (at_limit) begin
              beat_cnt <= '0;
              if (a_valid) begin
                last_b <= 1'b1;
                state  <= GNT_A;
              end
            end else begin
              beat_cnt <= cnt_inc;
            end
          end
          default: begin
            state    <= IDLE;
            beat_cnt <= '0;
          end
        endcase
      end
    end
  end

`ifdef VGA_ARB_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else if (stats_clr) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (acc_a && a_cnt != 16'hFFFF) a_cnt <= a_cnt + 16'd1;
      if (acc_b && b_cnt != 16'hFFFF) b_cnt <= b_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_wr_arbiter.sv
// tb/tb_vga_wr_arbiter.sv - self-checking bench for vga_wr_arbiter (directed + randomized, reference model)
module tb_vga_wr_arbiter;
  localparam int AW   = 19;
  localparam int DW   = 16;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wr_en = 1'b1;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic [AW-1:0] addr;
  logic [DW-1:0] dwrite;
  logic          wr;
  logic [1:0]    owner;
`ifdef VGA_ARB_STATS_EN
  logic          stats_clr = 1'b0;
  logic [15:0]   a_cnt, b_cnt;
`endif

  vga_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB), .BURST_W(3)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .addr(addr), .dwrite(dwrite), .wr(wr), .owner(owner)
`ifdef VGA_ARB_STATS_EN
    , .stats_clr(stats_clr), .a_cnt(a_cnt), .b_cnt(b_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: owner 0 idle / 1 A / 2 B, beats in current grant, last served requester.
  int            m_owner, m_cnt, m_last;
  logic          e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  int            e_acnt, e_bcnt;
  bit            last_acc_a, last_acc_b;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wlog_t;
  wlog_t wlog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_cnt = 0; m_last = 2;
    e_wr = 1'b0; e_addr = '0; e_data = '0;
    e_acnt = 0; e_bcnt = 0;
    last_acc_a = 1'b0; last_acc_b = 1'b0;
  endtask

  task automatic cycle();
    bit rdy_a, rdy_b, acc_a, acc_b, xv, ov;
    int x;
    @(negedge clk);
    cyc++;
    rdy_a = wr_en && (m_owner == 1);
    rdy_b = wr_en && (m_owner == 2);
    chk("a_ready", 32'(a_ready), 32'(rdy_a));
    chk("b_ready", 32'(b_ready), 32'(rdy_b));
    chk("owner",   32'(owner),   32'(m_owner));
    chk("wr",      32'(wr),      32'(e_wr));
    if (e_wr) begin
      chk("addr",   32'(addr),   32'(e_addr));
      chk("dwrite", 32'(dwrite), 32'(e_data));
    end
`ifdef VGA_ARB_STATS_EN
    chk("a_cnt", 32'(a_cnt), 32'(e_acnt));
    chk("b_cnt", 32'(b_cnt), 32'(e_bcnt));
`endif
    if (wr) wlog.push_back('{addr, dwrite, cyc});

    acc_a = a_valid && rdy_a;
    acc_b = b_valid && rdy_b;
    last_acc_a = acc_a;
    last_acc_b = acc_b;
    e_wr = acc_a || acc_b;
    if (acc_a) begin e_addr = a_addr; e_data = a_data; end
    if (acc_b) begin e_addr = b_addr; e_data = b_data; end
`ifdef VGA_ARB_STATS_EN
    if (stats_clr) begin
      e_acnt = 0; e_bcnt = 0;
    end else begin
      if (acc_a && e_acnt < 65535) e_acnt++;
      if (acc_b && e_bcnt < 65535) e_bcnt++;
    end
`endif
    if (wr_en) begin
      if (m_owner == 0) begin
        if (a_valid && b_valid) m_owner = (m_last == 2) ? 1 : 2;
        else if (a_valid)       m_owner = 1;
        else if (b_valid)       m_owner = 2;
      end else begin
        x  = m_owner;
        xv = (x == 1) ? a_valid : b_valid;
        ov = (x == 1) ? b_valid : a_valid;
        if (!xv) begin
          m_last = x; m_cnt = 0;
          m_owner = ov ? 3 - x : 0;
        end else begin
          m_cnt++;
          if (m_cnt == MAXB) begin
            m_cnt = 0;
            if (ov) begin m_last = x; m_owner = 3 - x; end
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic advance();
    if (last_acc_a) begin a_addr += 1; a_data = DW'($urandom); end
    if (last_acc_b) begin b_addr += 1; b_data = DW'($urandom); end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; wr_en = 1'b1;
    a_addr = 19'h100; b_addr = 19'h200;
    a_data = DW'($urandom); b_data = DW'($urandom);
    repeat (2) @(posedge clk);
    model_reset();
    #1 rstn = 1'b1;
    wlog.delete();
  endtask

  task automatic run_until_writes(input int n, input int budget, input string nm);
    int t = 0;
    while (wlog.size() < n && t < budget) begin
      cycle(); advance(); t++;
    end
    if (wlog.size() < n) chk({nm, "_timeout"}, 32'(wlog.size()), 32'(n));
  endtask

  initial begin
    int n, t;
    logic [AW-1:0] snap;

    do_reset();
    chk("rst_wr",     32'(wr),     32'h0);
    chk("rst_owner",  32'(owner),  32'h0);
    chk("rst_addr",   32'(addr),   32'h0);
    chk("rst_dwrite", 32'(dwrite), 32'h0);

    // A alone: three beats at 0x10..0x12.
    a_addr = 19'h10; a_data = 16'hA000; a_valid = 1'b1;
    n = 0; t = 0;
    while (n < 3 && t < 20) begin
      cycle(); t++;
      if (t == 1) chk("first_grant_owner", 32'(owner), 32'h1);
      if (last_acc_a) begin
        n++; a_addr += 1; a_data += 1;
        if (n == 3) a_valid = 1'b0;
      end
    end
    if (n < 3) chk("a_only_timeout", 32'(n), 32'd3);
    repeat (3) cycle();
    chk("a_only_nwrites", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      chk("a_only_addr0", 32'(wlog[0].addr), 32'h10);
      chk("a_only_addr2", 32'(wlog[2].addr), 32'h12);
      chk("a_only_data1", 32'(wlog[1].data), 32'hA001);
      chk("a_only_span",  32'(wlog[2].cyc - wlog[0].cyc), 32'd2);
    end

    // Both valid from IDLE: A first, then A x4 / B x4 / A x4 back-to-back.
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1;
    run_until_writes(12, 40, "alt");
    a_valid = 1'b0; b_valid = 1'b0;
    if (wlog.size() >= 12) begin
      for (int i = 0; i < 12; i++)
        chk("alt_addr", 32'(wlog[i].addr),
            (i < 4) ? 32'h100 + 32'(i) : (i < 8) ? 32'h200 + 32'(i - 4) : 32'h104 + 32'(i - 8));
      chk("alt_no_bubble", 32'(wlog[11].cyc - wlog[0].cyc), 32'd11);
    end
    repeat (3) cycle();

    // A drops valid after 2 beats with B waiting: one bubble then B.
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1;
    n = 0; t = 0;
    while (wlog.size() < 3 && t < 30) begin
      cycle(); t++;
      if (last_acc_a) begin n++; if (n == 2) a_valid = 1'b0; end
      advance();
    end
    chk("drop_nwrites", 32'(wlog.size() >= 3), 32'h1);
    if (wlog.size() >= 3) begin
      chk("drop_addr1",  32'(wlog[1].addr), 32'h101);
      chk("drop_addr2",  32'(wlog[2].addr), 32'h200);
      chk("drop_bubble", 32'(wlog[2].cyc - wlog[1].cyc), 32'd2);
    end
    b_valid = 1'b0;
    repeat (3) cycle();

    // wr_en low for 5 cycles after 2 A beats; burst resumes with count intact.
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1;
    n = 0; t = 0;
    while (n < 2 && t < 20) begin
      cycle(); t++;
      if (last_acc_a) n++;
      advance();
    end
    wr_en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cycle(); advance();
      chk("stall_wr",      32'(wr),      32'h0);
      chk("stall_a_ready", 32'(a_ready), 32'h0);
      chk("stall_owner",   32'(owner),   32'h1);
    end
    wr_en = 1'b1;
    run_until_writes(5, 30, "stall");
    if (wlog.size() >= 5) begin
      chk("stall_addr3", 32'(wlog[3].addr), 32'h103);
      chk("stall_addr4", 32'(wlog[4].addr), 32'h200);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (3) cycle();

    // Async reset mid-burst, then the first tie goes to A.
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1;
    run_until_writes(2, 20, "arst");
    #2 rstn = 1'b0;
    #1;
    chk("arst_wr",     32'(wr),     32'h0);
    chk("arst_owner",  32'(owner),  32'h0);
    chk("arst_addr",   32'(addr),   32'h0);
    chk("arst_dwrite", 32'(dwrite), 32'h0);
    model_reset();
    snap = a_addr;
    @(posedge clk);
    #1 rstn = 1'b1;
    wlog.delete();
    run_until_writes(1, 20, "arst_tie");
    if (wlog.size() >= 1) chk("arst_tie_a", 32'(wlog[0].addr), 32'(snap));
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (3) cycle();

`ifdef VGA_ARB_STATS_EN
    do_reset();
    a_valid = 1'b1; n = 0; t = 0;
    while (n < 10 && t < 40) begin
      cycle(); t++;
      if (last_acc_a) begin n++; if (n == 10) a_valid = 1'b0; end
      advance();
    end
    b_valid = 1'b1; n = 0; t = 0;
    while (n < 3 && t < 40) begin
      cycle(); t++;
      if (last_acc_b) begin n++; if (n == 3) b_valid = 1'b0; end
      advance();
    end
    repeat (2) cycle();
    chk("stats_a10", 32'(a_cnt), 32'd10);
    chk("stats_b3",  32'(b_cnt), 32'd3);
    a_valid = 1'b1; n = 0; t = 0;
    while (n == 0 && t < 20) begin
      stats_clr = (m_owner == 1);
      cycle(); t++;
      if (last_acc_a && stats_clr) n = 1;
      stats_clr = 1'b0;
      advance();
    end
    chk("stats_clr_wins", 32'(a_cnt), 32'd0);
    a_valid = 1'b0;
    repeat (3) cycle();
`endif

    // Randomized traffic; requesters only change a pending beat once it is accepted.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      wr_en = ($urandom_range(0, 9) != 0);
      if (!a_valid || last_acc_a) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_addr = AW'($urandom); a_data = DW'($urandom);
      end
      if (!b_valid || last_acc_b) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_addr = AW'($urandom); b_data = DW'($urandom);
      end
`ifdef VGA_ARB_STATS_EN
      stats_clr = ($urandom_range(0, 49) == 0);
`endif
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vga_wr_arbiter.md
Name: vga_wr_arbiter

Overview:
Round-robin arbiter that shares the single framebuffer write port between two requesters (A: draw engine, B: text/overlay writer). It replaces free-running time-slice muxing with a valid/ready handshake. Bursts are bounded and the output write is registered. It sits between the two pixel writers and the VGA framebuffer RAM write port.

Parameters:
ADDR_W, 19, framebuffer address width
DATA_W, 16, pixel word width
MAX_BURST, 64, max beats one requester may write consecutively while the other waits (>=1)
BURST_W, 7, width of beat counter; must hold MAX_BURST

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
wr_en  in  1  global write enable; low = freeze arbitration, accept nothing
a_valid  in  1  requester A has a write pending
a_ready  out  1  A beat accepted this cycle when a_valid&a_ready
a_addr  in  ADDR_W  A write address
a_data  in  DATA_W  A write data
b_valid  in  1  requester B has a write pending
b_ready  out  1  B handshake, as a_ready
b_addr  in  ADDR_W  B write address
b_data  in  DATA_W  B write data
addr  out  ADDR_W  framebuffer write address (registered)
dwrite  out  DATA_W  framebuffer write data (registered)
wr  out  1  framebuffer write strobe, one cycle per accepted beat
owner  out  2  current grant: 00 idle, 01 A, 10 B

Behaviour:
- Reset values: state IDLE; addr=0; dwrite=0; wr=0; owner=00; beat count 0; last_served=B, so A wins the first tie. Reset is async; wr drops immediately.
- States are IDLE, GNT_A and GNT_B.
- a_ready = wr_en & (state==GNT_A). b_ready = wr_en & (state==GNT_B). Both are combinational from registered state.
- Accepted beat: the valid&ready cycle. On the next edge, addr/dwrite take that beat's values and wr=1, giving latency 1. With no accepted beat, wr=0 and addr/dwrite hold.
- Handshake rule: a requester holds addr/data stable while valid and not ready. The block never drops an accepted beat.
- IDLE: only one valid -> grant it. Both valid -> grant the one that is not last_served. Neither valid -> stay. The grant takes effect next cycle, so the first grant costs one dead cycle.
- GNT_x, per accepted beat: the beat counter increments.
- Leaving GNT_x:
  - x_valid low in the current cycle: go to GNT_other if other_valid, else IDLE.
  - Beat counter reaches MAX_BURST on an accepted beat and other_valid: go to GNT_other.
  - Beat counter reaches MAX_BURST on an accepted beat and other not valid: stay in GNT_x and clear the counter.
- On any state change, the beat counter clears and last_served becomes the departing requester.
- A grant switch triggered by x_valid low costs one bubble cycle (ready shown, no valid). A switch on burst limit is back-to-back, with no bubble.
- wr_en low: both readies low in the same cycle. State, beat counter and last_served hold. Transitions are evaluated only while wr_en=1.
- owner mirrors state.
- Beat counter arithmetic is unsigned BURST_W and never wraps past MAX_BURST.

Optional Feature:
Macro VGA_ARB_STATS_EN.
- Defined: adds outputs a_cnt and b_cnt, each 16 bits.
  - Each is a saturating count of accepted beats per requester; it sticks at 0xFFFF.
  - Cleared by rstn and by new input stats_clr, a 1-bit synchronous clear that wins over a same-cycle increment.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then A only valid, 3 beats at addr 0x00010..0x00012 -> owner=01 after 1 cycle; wr pulses 3 consecutive cycles, each one cycle after its a_ready handshake, with matching addr/dwrite.
- A and B valid together from IDLE -> A granted first; B waits.
- MAX_BURST=4, A and B continuously valid -> writes alternate A x4, B x4, A x4; no bubble cycle at the switches.
- A bursting, a_valid drops after 2 beats, b_valid high -> exactly one wr=0 bubble, then B granted.
- wr_en low for 5 cycles mid-burst -> a_ready/b_ready=0 and wr=0 throughout; beat count and owner unchanged; the burst resumes after wr_en rises.
- rstn asserted mid-burst -> wr, owner, addr and dwrite go to 0 without waiting for a clock edge; after release the first tie goes to A.
- VGA_ARB_STATS_EN: 10 A beats and 3 B beats -> a_cnt=10, b_cnt=3.
- VGA_ARB_STATS_EN: stats_clr asserted in the same cycle as an accepted beat -> the counter reads 0.
